lsu_mem_port: RTL and testbench
===============================

// Module: lsu_mem_port
// PURPOSE
//  Load/store initiator between the core's memory stage and the byte-addressed data RAM.
//  - Accepts one request at a time over a valid/ready handshake.
//  - Issues combinational-read / posedge-write accesses to the RAM.
//  - Handles LB/LH/LW/LBU/LHU/SB/SH/SW; sub-word stores use read-modify-write because RAM w_en writes 4 bytes.
//  - Returns a registered response that the core must accept with resp_ready.
// PARAMETERS
//  RAM_SZ      8192  RAM size in bytes; an access is in range iff addr+3 <= RAM_SZ-1
// PORTS
//  clk          in   1   single clock, posedge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted on posedge when req_valid && req_ready
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   0=byte 1=half 2=word (3 = illegal -> err)
//  req_unsigned in   1   loads only: zero-extend instead of sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data (low byte/half used for SB/SH)
//  resp_valid   out  1   response present; held until resp_ready
//  resp_ready   in   1   core accepts response
//  resp_rdata   out  32  extended load data; 0 for stores and errors
//  resp_err     out  1   range/size/alignment error; no memory write was issued
//  mem_addr     out  32  RAM byte address
//  mem_w_en     out  1   RAM write enable (one cycle per store)
//  mem_wdata    out  32  RAM write data, little-endian (bits[7:0] -> mem_addr)
//  mem_rdata    in   32  RAM combinational read data at mem_addr
// BEHAVIOUR
//  - States: IDLE, LOAD, RMW_RD, WRITE, RESP. Reset -> IDLE.
//  - Outputs in reset: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_w_en=0, mem_addr=0, mem_wdata=0.
//  - req_ready = (state==IDLE); accept latches we/size/unsigned/addr/wdata.
//  - Error check at accept: size==3, or addr+3 >= RAM_SZ (computed in 33 bits, no wrap), or misaligned under MISALIGN_TRAP_EN.
//    Error -> RESP with err=1 and rdata=0; no RAM access.
//  - IDLE->LOAD (load) | RMW_RD (SB/SH) | WRITE (SW) | RESP (error).
//  - LOAD: mem_addr=addr; at posedge, capture lane0 of mem_rdata, sign/zero-extended per size -> RESP.
//  - RMW_RD: mem_addr=addr; capture mem_rdata, replace low 8/16 bits with wdata -> WRITE.
//  - WRITE: mem_w_en=1 for exactly one cycle; mem_wdata = merged word (SB/SH) or wdata (SW) -> RESP.
//  - RESP: resp_valid=1; on resp_ready -> IDLE. No new request is accepted in the same cycle.
//  - Latency from accept edge to resp_valid: LW/LB/LH/SW = 2 edges, SB/SH = 3 edges, error = 1 edge.
//  - mem_w_en is decoded from state==WRITE only.
//    Async reset mid-operation drops mem_w_en immediately and abandons the request with no response.
//  - mem_addr holds the latched addr in LOAD/RMW_RD/WRITE and is 0 otherwise.
// CONFIGURATION
//  - MISALIGN_TRAP_EN defined: half at an odd address, or word with addr[1:0]!=0, returns err=1 and issues no access.
//  - MISALIGN_TRAP_EN undefined: misaligned accesses proceed at the byte address given, since RAM supports unaligned 4-byte windows.
// STRUCTURE
//  - Package lsu_pkg:
//    - lsu_state_e enum.
//    - Size localparams SZ_B=0, SZ_H=1, SZ_W=2.
//    - function ext_load(word, size, unsigned).
//    - function merge_store(old, wdata, size).
//  - Sub-module lsu_lane: combinational extend/merge around the lsu_pkg functions, instantiated once.
// TESTING
//  1. After reset, LW addr=0x40 on untouched RAM (init 0xac bytes) -> resp_rdata=0xacacacac, err=0, 2 edges.
//  2. LB addr=0x41 -> 0xffffffac; LBU addr=0x41 -> 0x000000ac; LH addr=0x42 -> 0xffffacac.
//  3. SW 0x12345678 @0x10, then SB 0x000000ee @0x11 -> exactly 2 mem_w_en pulses;
//     LW @0x10 = 0x1234ee78; SB latency 3 edges.
//  4. LW addr=RAM_SZ-2 -> err=1, rdata=0, mem_w_en never high; size=3 -> err=1.
//  5. MISALIGN_TRAP_EN: SH @0x21 -> err=1, no write. Without it: SH 0xbeef @0x21 -> LW @0x20 = 0xacbeefac.
//  6. Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0.
//     Assert rst_n=0 during WRITE -> mem_w_en falls asynchronously and the RAM word is unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and data-path helpers for the load/store memory port.
// States, access-size codes, load extension and sub-word store merge.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [31:0] ext_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] r;
        r = word;
        if (size == SZ_B) begin
            r = uns ? {24'd0, word[7:0]}
                    : {{24{word[7]}}, word[7:0]};
        end else if (size == SZ_H) begin
            r = uns ? {16'd0, word[15:0]}
                    : {{16{word[15]}}, word[15:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] merge_store(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = wdata;
        if (size == SZ_B) begin
            r = {old[31:8], wdata[7:0]};
        end else if (size == SZ_H) begin
            r = {old[31:16], wdata[15:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core request/response handshake plus RAM access bus.
// slave: the memory port; master: the core and RAM side.
interface lsu_mem_port_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_addr;
    logic        mem_w_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_addr, mem_w_en, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_addr, mem_w_en, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_lane.sv
// Combinational lane logic: extend a loaded word, merge a sub-word
// store into the word read back from RAM.
import lsu_pkg::*;

module lsu_lane (
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    assign ld_data = ext_load(word, size, uns);
    assign st_data = merge_store(word, wdata, size);

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the memory stage and the byte RAM.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
import lsu_pkg::*;

module lsu_mem_port #(
    parameter int unsigned RAM_SZ = 8192
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_port_if.slave bus
);

    lsu_state_e state;
    lsu_state_e state_n;

    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        acc;
    logic        bad;
    logic [32:0] end_a;
    logic [31:0] ld_w;
    logic [31:0] st_w;

    assign acc   = bus.req_valid && bus.req_ready;
    assign end_a = {1'b0, bus.req_addr} + 33'd3;

    // Range check in 33 bits so addresses near 2^32 cannot wrap in range.
    always_comb begin
        bad = (bus.req_size == 2'd3)
            || (end_a >= 33'(RAM_SZ));
`ifdef MISALIGN_TRAP_EN
        if (bus.req_size == SZ_H && bus.req_addr[0])
            bad = 1'b1;
        if (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00)
            bad = 1'b1;
`endif
    end

    lsu_lane u_lane (
        .word    (bus.mem_rdata),
        .wdata   (wd_q),
        .size    (size_q),
        .uns     (uns_q),
        .ld_data (ld_w),
        .st_data (st_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (acc) begin
                    if (bad)                 state_n = ST_RESP;
                    else if (!bus.req_we)    state_n = ST_LOAD;
                    else if (bus.req_size == SZ_W)
                                             state_n = ST_WRITE;
                    else                     state_n = ST_RMW_RD;
                end
            end
            ST_LOAD:   state_n = ST_RESP;
            ST_RMW_RD: state_n = ST_WRITE;
            ST_WRITE:  state_n = ST_RESP;
            ST_RESP:   if (bus.resp_ready) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (acc) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wd_q    <= bus.req_wdata;
                rdata_q <= '0;
                err_q   <= bad;
            end
            if (state == ST_LOAD)
                rdata_q <= ld_w;
            // Sub-word store: wd_q becomes the full merged word.
            if (state == ST_RMW_RD && we_q)
                wd_q <= st_w;
        end
    end

    logic mem_act;
    assign mem_act = (state == ST_LOAD)
                  || (state == ST_RMW_RD)
                  || (state == ST_WRITE);

    assign bus.req_ready  = rst_n && (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_addr   = mem_act ? addr_q : 32'd0;
    assign bus.mem_w_en   = (state == ST_WRITE);
    assign bus.mem_wdata  = (state == ST_WRITE) ? wd_q : 32'd0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port against a byte-array RAM model.
// Build with MISALIGN_TRAP_EN to exercise the misalignment trap.
module tb_lsu_mem_port;

    localparam int unsigned RAM_SZ = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_port_if bus ();

    lsu_mem_port #(.RAM_SZ(RAM_SZ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] ram [RAM_SZ];
    int wcnt   = 0;
    int checks = 0;
    int errors = 0;

    initial for (int i = 0; i < int'(RAM_SZ); i++) ram[i] = 8'hac;

    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 4; i++)
            if ((33'(bus.mem_addr) + 33'(i)) < 33'(RAM_SZ))
                bus.mem_rdata[8*i +: 8] = ram[bus.mem_addr + 32'(i)];
    end

    always @(posedge clk) begin
        if (bus.mem_w_en) begin
            wcnt++;
            for (int i = 0; i < 4; i++)
                if ((33'(bus.mem_addr) + 33'(i)) < 33'(RAM_SZ))
                    ram[bus.mem_addr + 32'(i)] <= bus.mem_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input int a);
        return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
    endfunction

    task automatic xfer(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        input logic [31:0] hexp,
                        output logic [31:0] rd, output logic err,
                        output int lat);
        int n;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = bus.resp_rdata;
        err = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_rdata", bus.resp_rdata, hexp);
            chk("hold_rdy", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    int          w0;

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        chk("rst_w_en", 32'(bus.mem_w_en), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);

        xfer(0, 2'd2, 0, 32'h40, 0, 0, 0, rd, err, lat);
        chk("lw_data", rd, 32'hacacacac);
        chk("lw_err", 32'(err), 32'd0);
        chk("lw_lat", 32'(lat), 32'd2);

        xfer(0, 2'd0, 0, 32'h41, 0, 0, 0, rd, err, lat);
        chk("lb_data", rd, 32'hffffffac);
        chk("lb_lat", 32'(lat), 32'd2);
        xfer(0, 2'd0, 1, 32'h41, 0, 0, 0, rd, err, lat);
        chk("lbu_data", rd, 32'h000000ac);
        xfer(0, 2'd1, 0, 32'h42, 0, 0, 0, rd, err, lat);
        chk("lh_data", rd, 32'hffffacac);
        chk("lh_lat", 32'(lat), 32'd2);

        w0 = wcnt;
        xfer(1, 2'd2, 0, 32'h10, 32'h12345678, 0, 0, rd, err, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_rdata", rd, 32'd0);
        xfer(1, 2'd0, 0, 32'h11, 32'h000000ee, 0, 0, rd, err, lat);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_err", 32'(err), 32'd0);
        chk("st_pulses", 32'(wcnt - w0), 32'd2);
        xfer(0, 2'd2, 0, 32'h10, 0, 0, 0, rd, err, lat);
        chk("rmw_word", rd, 32'h1234ee78);

        w0 = wcnt;
        xfer(0, 2'd2, 0, RAM_SZ - 2, 0, 0, 0, rd, err, lat);
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        chk("oor_lat", 32'(lat), 32'd1);
        xfer(1, 2'd2, 0, RAM_SZ - 2, 32'h55, 0, 0, rd, err, lat);
        chk("oor_st_err", 32'(err), 32'd1);
        xfer(0, 2'd3, 0, 32'h40, 0, 0, 0, rd, err, lat);
        chk("sz3_err", 32'(err), 32'd1);
        chk("err_no_wr", 32'(wcnt - w0), 32'd0);
        xfer(0, 2'd2, 0, RAM_SZ - 4, 0, 0, 0, rd, err, lat);
        chk("edge_err", 32'(err), 32'd0);
        chk("edge_data", rd, 32'hacacacac);

        w0 = wcnt;
        xfer(1, 2'd1, 0, 32'h21, 32'h0000beef, 0, 0, rd, err, lat);
`ifdef MISALIGN_TRAP_EN
        chk("sh_mis_err", 32'(err), 32'd1);
        chk("sh_mis_nowr", 32'(wcnt - w0), 32'd0);
        xfer(0, 2'd2, 0, 32'h20, 0, 0, 0, rd, err, lat);
        chk("sh_mis_word", rd, 32'hacacacac);
`else
        chk("sh_una_err", 32'(err), 32'd0);
        chk("sh_una_lat", 32'(lat), 32'd3);
        chk("sh_una_wr", 32'(wcnt - w0), 32'd1);
        xfer(0, 2'd2, 0, 32'h20, 0, 0, 0, rd, err, lat);
        chk("sh_una_word", rd, 32'hacbeefac);
`endif

        xfer(0, 2'd2, 0, 32'h10, 0, 5, 32'h1234ee78, rd, err, lat);
        chk("hold_data", rd, 32'h1234ee78);

        w0 = wcnt;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h80;
        bus.req_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("wr_w_en", 32'(bus.mem_w_en), 32'd1);
        chk("wr_addr", bus.mem_addr, 32'h80);
        chk("wr_wdata", bus.mem_wdata, 32'h11223344);
        rst_n = 1'b0;
        #1;
        chk("arst_w_en", 32'(bus.mem_w_en), 32'd0);
        chk("arst_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("arst_nowr", 32'(wcnt - w0), 32'd0);
        chk("arst_ram", ram_word(32'h80), 32'hacacacac);
        @(negedge clk);
        chk("arst_noresp", 32'(bus.resp_valid), 32'd0);
        xfer(0, 2'd2, 0, 32'h80, 0, 0, 0, rd, err, lat);
        chk("arst_lw", rd, 32'hacacacac);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
